datapath: RTL and testbench

Execution datapath of the Simple RISC Machine, sitting directly downstream of the `fsm` controller and driven by its load/select/write strobes. It contains:
- an 8×16-bit register file;
- pipeline registers A, B and C;
- a barrel-style 1-bit shifter;
- a 4-function ALU;
- a 3-bit status register.

All architectural state changes on the rising clock edge under controller strobes. Register read addresses and immediates come from the instruction decoder.

---
 rtl/datapath.sv | 120 ++++++++++++
 tb/tb_datapath.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Simple RISC Machine execution datapath: 8x16 register file, A/B/C pipeline
// registers, 1-bit shifter, 4-function ALU and {V,N,Z} status register.
module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [2:0]  writenum,
  input  logic [2:0]  readnum,
  input  logic [1:0]  vsel,
  input  logic        loada,
  input  logic        loadb,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  shift,
  input  logic [1:0]  ALUop,
  input  logic        loadc,
  input  logic        loads,
  input  logic [15:0] sximm8,
  input  logic [15:0] sximm5,
  input  logic [15:0] mdata,
  output logic [15:0] datapath_out,
  output logic [2:0]  Z_out
);

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;
  localparam logic [1:0] VSEL_MEM  = 2'b10;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [15:0] rf_q [8];
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic [2:0]  status_q, status_d;

  logic [15:0] rdata;
  logic [15:0] wdata;
  logic [15:0] sout;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] result;
  logic        ovf;

  // Read sees the pre-edge contents; no bypass from a same-cycle write.
  assign rdata = rf_q[readnum];

  always_comb begin
    wdata = '0;
    case (vsel)
      VSEL_C:    wdata = c_q;
      VSEL_IMM8: wdata = sximm8;
      VSEL_MEM:  wdata = mdata;
      default:   wdata = '0;
    endcase
  end

  always_comb begin
    sout = b_q;
    case (shift)
      SH_PASS: sout = b_q;
      SH_LSL:  sout = {b_q[14:0], 1'b0};
      SH_LSR:  sout = {1'b0, b_q[15:1]};
      default: sout = {b_q[15], b_q[15:1]};
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : sout;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (ALUop)
      OP_ADD: begin
        result = ain + bin;
        ovf    = (ain[15] == bin[15]) && (result[15] != ain[15]);
      end
      OP_SUB: begin
        result = ain - bin;
        ovf    = (ain[15] != bin[15]) && (result[15] != ain[15]);
      end
      OP_AND:  result = ain & bin;
      default: result = ~bin;
    endcase
  end

  always_comb begin
    a_d      = loada ? rdata : a_q;
    b_d      = loadb ? rdata : b_q;
    c_d      = loadc ? result : c_q;
    status_d = loads ? {ovf, result[15], (result == 16'h0000)} : status_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (write) rf_q[writenum] <= wdata;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = status_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: behavioural model compared every cycle,
// directed instruction sequences with literal expectations, then random traffic.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  writenum, readnum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5, mdata;
  logic [15:0] datapath_out;
  logic [2:0]  Z_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] mR [8];
  logic [15:0] mA, mB, mC;
  logic [2:0]  mS;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum),
    .readnum(readnum), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .sximm8(sximm8), .sximm5(sximm5),
    .mdata(mdata), .datapath_out(datapath_out), .Z_out(Z_out)
  );

  function automatic int sval(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  // Next architectural state from the current inputs, using plain arithmetic.
  task automatic model_step();
    logic [15:0] rd, av, bv, sh, res, wd;
    int full;
    logic v;
    rd = mR[readnum];
    av = asel ? 16'h0 : mA;
    case (shift)
      2'd0: sh = mB;
      2'd1: sh = 16'((32'(mB) * 2) % 65536);
      2'd2: sh = mB / 2;
      default: sh = (mB / 2) + (mB >= 16'h8000 ? 16'h8000 : 16'h0);
    endcase
    bv = bsel ? sximm5 : sh;
    v = 1'b0;
    case (ALUop)
      2'd0: begin full = sval(av) + sval(bv); res = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd1: begin full = sval(av) - sval(bv); res = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd2: res = av & bv;
      default: res = 16'hFFFF - bv;
    endcase
    wd = (vsel == 2'd0) ? mC : (vsel == 2'd1) ? sximm8 : (vsel == 2'd2) ? mdata : 16'h0;
    if (reset) begin
      for (int i = 0; i < 8; i++) mR[i] = 16'h0;
      mA = 0; mB = 0; mC = 0; mS = 0;
    end else begin
      if (write) mR[writenum] = wd;
      if (loada) mA = rd;
      if (loadb) mB = rd;
      if (loadc) mC = res;
      if (loads) mS = {v, res[15], res == 16'h0};
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (datapath_out !== mC) begin
      errors++;
      $display("FAIL model_out t=%0t got=%h want=%h", $time, datapath_out, mC);
    end
    checks++;
    if (Z_out !== mS) begin
      errors++;
      $display("FAIL model_flags t=%0t got=%b want=%b", $time, Z_out, mS);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    reset = 0; write = 0; loada = 0; loadb = 0; asel = 0; bsel = 0;
    loadc = 0; loads = 0; writenum = 0; readnum = 0; vsel = 0;
    shift = 0; ALUop = 0; sximm8 = 0; sximm5 = 0; mdata = 0;
  endtask

  task automatic mov(input logic [2:0] rd, input logic [15:0] val);
    clr(); write = 1; vsel = 2'b01; writenum = rd; sximm8 = val; tick();
  endtask

  // Copies R[r] into C via B with A forced to zero.
  task automatic readreg(input logic [2:0] r);
    clr(); loadb = 1; readnum = r; tick();
    clr(); asel = 1; loadc = 1; tick();
  endtask

  initial begin
    clr();
    for (int i = 0; i < 8; i++) mR[i] = 16'h0;
    mA = 0; mB = 0; mC = 0; mS = 0;
    @(negedge clk);

    reset = 1; tick(); clr();
    lit("reset_out", datapath_out, 16'h0);
    lit("reset_flags", 16'(Z_out), 16'h0);
    for (int i = 0; i < 8; i++) begin
      readreg(3'(i));
      lit("reset_reg", datapath_out, 16'h0);
    end

    mov(3'd0, 16'h0007);
    mov(3'd1, 16'h0002);
    clr(); loada = 1; readnum = 0; tick();
    clr(); loadb = 1; readnum = 1; tick();
    clr(); shift = 2'b01; ALUop = 2'b00; loadc = 1; loads = 1; tick();
    lit("add_out", datapath_out, 16'h000B);
    lit("add_flags", 16'(Z_out), 16'h0000);
    clr(); write = 1; vsel = 2'b00; writenum = 2; tick();
    readreg(3'd2);
    lit("add_r2", datapath_out, 16'h000B);

    mov(3'd3, 16'h7FFF);
    mov(3'd4, 16'hFFFF);
    clr(); loada = 1; readnum = 3; tick();
    clr(); loadb = 1; readnum = 4; tick();
    clr(); ALUop = 2'b01; loads = 1; tick();
    lit("cmp_ovf_flags", 16'(Z_out), 16'h0006);
    lit("cmp_keeps_c", datapath_out, 16'h000B);

    mov(3'd5, 16'h0005);
    clr(); loada = 1; loadb = 1; readnum = 5; tick();
    clr(); ALUop = 2'b01; loads = 1; tick();
    lit("cmp_eq_flags", 16'(Z_out), 16'h0001);

    mov(3'd6, 16'h8004);
    clr(); loadb = 1; readnum = 6; tick();
    clr(); shift = 2'b11; asel = 1; ALUop = 2'b00; loadc = 1; loads = 1; tick();
    lit("asr_out", datapath_out, 16'hC002);
    lit("asr_n", 16'(Z_out[1]), 16'h0001);

    mov(3'd7, 16'h00FF);
    clr(); loadb = 1; readnum = 7; tick();
    clr(); ALUop = 2'b11; loadc = 1; loads = 1; tick();
    lit("mvn_out", datapath_out, 16'hFF00);
    lit("mvn_flags", 16'(Z_out), 16'h0002);

    clr(); loada = 1; readnum = 0; tick();
    clr(); loadb = 1; readnum = 1; tick();
    clr(); reset = 1; loadc = 1; loads = 1; write = 1; sximm8 = 16'h1234; vsel = 2'b01; tick();
    lit("midreset_out", datapath_out, 16'h0);
    lit("midreset_flags", 16'(Z_out), 16'h0);
    clr(); loadc = 1; loads = 1; tick();
    lit("post_reset_add", datapath_out, 16'h0);
    lit("post_reset_z", 16'(Z_out), 16'h0001);

    mov(3'd1, 16'h0009);
    readreg(3'd1);
    clr(); write = 1; vsel = 2'b00; writenum = 2; asel = 1; ALUop = 2'b11; loadc = 1; tick();
    lit("wr_new_c", datapath_out, 16'hFFF6);
    readreg(3'd2);
    lit("wr_old_c", datapath_out, 16'h0009);

    clr(); write = 1; vsel = 2'b01; writenum = 3; sximm8 = 16'hAAAA; loadb = 1; readnum = 3; tick();
    clr(); asel = 1; loadc = 1; tick();
    lit("no_bypass", datapath_out, 16'h0000);
    readreg(3'd3);
    lit("write_landed", datapath_out, 16'hAAAA);

    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      write    = 1'($urandom);
      writenum = 3'($urandom);
      readnum  = 3'($urandom);
      vsel     = 2'($urandom);
      loada    = 1'($urandom);
      loadb    = 1'($urandom);
      asel     = ($urandom_range(0, 3) == 0);
      bsel     = ($urandom_range(0, 3) == 0);
      shift    = 2'($urandom);
      ALUop    = 2'($urandom);
      loadc    = 1'($urandom);
      loads    = 1'($urandom);
      sximm8   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      sximm5   = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      mdata    = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
